// File: rtl/bcp_clause_engine_if.sv
// Register-block <-> clause engine signal bundle: clause loads, assignment snapshot,
// start pulse, and the scan results returned for software readback.
interface bcp_clause_engine_if #(
    parameter int NUM_VARS = 32,
    parameter int VAR_W    = 5,
    parameter int CIDX_W   = 4,
    parameter int LITS     = 3
);
    logic                        clause_wr_en;
    logic [CIDX_W-1:0]           clause_wr_idx;
    logic [LITS*(VAR_W+2)-1:0]   clause_wr_data;
    logic [CIDX_W:0]             num_clauses;
    logic [NUM_VARS-1:0]         assign_val;
    logic [NUM_VARS-1:0]         assign_def;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        conflict;
    logic [CIDX_W-1:0]           conflict_idx;
    logic                        unit_found;
    logic [VAR_W+1:0]            unit_lit;
    logic [CIDX_W-1:0]           unit_idx;

    modport master (
        output clause_wr_en, clause_wr_idx, clause_wr_data, num_clauses,
               assign_val, assign_def, start,
        input  busy, done, conflict, conflict_idx, unit_found, unit_lit, unit_idx
    );

    modport slave (
        input  clause_wr_en, clause_wr_idx, clause_wr_data, num_clauses,
               assign_val, assign_def, start,
        output busy, done, conflict, conflict_idx, unit_found, unit_lit, unit_idx
    );
endinterface

// File: rtl/bcp_clause_engine.sv
// Boolean constraint propagation engine: scans a small clause memory one slot per cycle
// against a snapshot of the partial assignment, reporting the first unit and first conflict.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | accepts clause writes; start snapshots inputs and launches scan
// S_EVAL   | evaluates slot r_ptr this cycle; stops early on a conflict
// S_FINISH | one-cycle done pulse, results held until next start
module bcp_clause_engine #(
    parameter int NUM_VARS    = 32,
    parameter int VAR_W       = 5,
    parameter int MAX_CLAUSES = 16,
    parameter int CIDX_W      = 4,
    parameter int LITS        = 3
) (
    input  logic                ACLK,
    input  logic                ARESET,
    bcp_clause_engine_if.slave  bus
);
    localparam int LIT_W = VAR_W + 2;
    localparam int CLS_W = LITS * LIT_W;
    localparam int CNT_W = $clog2(LITS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CLS_W-1:0]    r_mem [MAX_CLAUSES];
    logic [CIDX_W-1:0]   r_ptr;
    logic [CIDX_W:0]     r_count;
    logic [NUM_VARS-1:0] r_val;
    logic [NUM_VARS-1:0] r_def;

    logic                r_conflict;
    logic [CIDX_W-1:0]   r_conflict_idx;
    logic                r_unit_found;
    logic [LIT_W-1:0]    r_unit_lit;
    logic [CIDX_W-1:0]   r_unit_idx;

    logic [CLS_W-1:0]    w_clause;
    logic [LIT_W-1:0]    w_lit;
    logic                w_any_true;
    logic [CNT_W-1:0]    w_unas_cnt;
    logic [LIT_W-1:0]    w_unit_lit;
    logic                w_is_conflict;
    logic                w_is_unit;
    logic                w_last;
    logic [CIDX_W:0]     w_cnt_sat;
    logic                w_accept;
    logic                w_wr;

    // Literal classification for the slot under the pointer; an all-invalid slot
    // has no true and no unassigned literal, so it falls out as a conflict.
    always_comb begin
        w_clause   = r_mem[r_ptr];
        w_lit      = '0;
        w_any_true = 1'b0;
        w_unas_cnt = '0;
        w_unit_lit = '0;
        for (int i = 0; i < LITS; i++) begin
            w_lit = w_clause[i*LIT_W +: LIT_W];
            if (w_lit[LIT_W-1]) begin
                if (!r_def[w_lit[VAR_W-1:0]]) begin
                    w_unas_cnt = w_unas_cnt + CNT_W'(1);
                    w_unit_lit = w_lit;
                end else if (r_val[w_lit[VAR_W-1:0]] ^ w_lit[VAR_W]) begin
                    w_any_true = 1'b1;
                end
            end
        end
        w_is_conflict = !w_any_true && (w_unas_cnt == CNT_W'(0));
        w_is_unit     = !w_any_true && (w_unas_cnt == CNT_W'(1));
    end

    assign w_last    = ((CIDX_W+1)'(r_ptr) + (CIDX_W+1)'(1)) == r_count;
    assign w_cnt_sat = (bus.num_clauses > (CIDX_W+1)'(MAX_CLAUSES)) ?
                       (CIDX_W+1)'(MAX_CLAUSES) : bus.num_clauses;
    assign w_wr      = bus.clause_wr_en && (r_state == S_IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_cnt_sat == '0) ? S_FINISH : S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_is_conflict || w_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < MAX_CLAUSES; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr          <= '0;
            r_count        <= '0;
            r_val          <= '0;
            r_def          <= '0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_unit_found   <= 1'b0;
            r_unit_lit     <= '0;
            r_unit_idx     <= '0;
        end else begin
            if (w_wr) begin
                r_mem[bus.clause_wr_idx] <= bus.clause_wr_data;
            end
            if (w_accept) begin
                r_val          <= bus.assign_val;
                r_def          <= bus.assign_def;
                r_count        <= w_cnt_sat;
                r_ptr          <= '0;
                r_conflict     <= 1'b0;
                r_conflict_idx <= '0;
                r_unit_found   <= 1'b0;
                r_unit_lit     <= '0;
                r_unit_idx     <= '0;
            end else if (r_state == S_EVAL) begin
                r_ptr <= r_ptr + CIDX_W'(1);
                if (w_is_conflict) begin
                    r_conflict     <= 1'b1;
                    r_conflict_idx <= r_ptr;
                end else if (w_is_unit && !r_unit_found) begin
                    r_unit_found <= 1'b1;
                    r_unit_lit   <= w_unit_lit;
                    r_unit_idx   <= r_ptr;
                end
            end
        end
    end

    assign bus.busy         = (r_state == S_EVAL);
    assign bus.done         = (r_state == S_FINISH);
    assign bus.conflict     = r_conflict;
    assign bus.conflict_idx = r_conflict_idx;
    assign bus.unit_found   = r_unit_found;
    assign bus.unit_lit     = r_unit_lit;
    assign bus.unit_idx     = r_unit_idx;
endmodule

// File: tb/tb_bcp_clause_engine.sv
// Directed bench for bcp_clause_engine: hand-computed latencies and flags for reset,
// satisfied/unit/conflict clauses, busy guards, count saturation and mid-scan reset.
module tb_bcp_clause_engine;
    logic ACLK = 1'b0;
    logic ARESET;
    int   tests = 0;
    int   fails = 0;

    bcp_clause_engine_if bus ();

    bcp_clause_engine dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [20:0] d);
        @(posedge ACLK); #1;
        bus.clause_wr_en   = 1'b1;
        bus.clause_wr_idx  = 4'(idx);
        bus.clause_wr_data = d;
        @(posedge ACLK); #1;
        bus.clause_wr_en   = 1'b0;
    endtask

    // Start at cycle T; cycle n below is T+n. inj_kind 1 = start/write/assign change
    // while busy, 2 = reset pulse.
    task automatic scan(input int cnt, input int inj_cyc, input int inj_kind, input int max_cyc,
                        output int done_cyc, output int busy_n, output int busy_first,
                        output int busy_last, output bit done_after);
        int n;
        bus.num_clauses = 5'(cnt);
        @(posedge ACLK); #1;
        bus.start = 1'b1;
        @(posedge ACLK); #1;
        bus.start = 1'b0;
        n = 1; done_cyc = -1; busy_n = 0; busy_first = -1; busy_last = -1; done_after = 1'b0;
        while (n <= max_cyc && done_cyc < 0) begin
            if (n == inj_cyc && inj_kind == 1) begin
                bus.start          = 1'b1;
                bus.clause_wr_en   = 1'b1;
                bus.clause_wr_idx  = 4'd4;
                bus.clause_wr_data = 21'h0;
                bus.assign_def     = '1;
            end
            if (n == inj_cyc && inj_kind == 2) ARESET = 1'b1;
            if (n == inj_cyc + 1) begin
                bus.start = 1'b0; bus.clause_wr_en = 1'b0; ARESET = 1'b0;
            end
            if (bus.busy) begin
                busy_n++;
                if (busy_first < 0) busy_first = n;
                busy_last = n;
            end
            if (bus.done) done_cyc = n;
            if (done_cyc < 0) begin
                @(posedge ACLK); #1;
                n++;
            end
        end
        bus.start = 1'b0; bus.clause_wr_en = 1'b0; ARESET = 1'b0;
        if (inj_kind == 1) bus.assign_def = '0;
        if (done_cyc >= 0) begin
            @(posedge ACLK); #1;
            done_after = bus.done;
        end
    endtask

    initial begin
        int dc, bn, bf, bl;
        bit da;
        ARESET = 1'b1;
        bus.clause_wr_en = 1'b0; bus.clause_wr_idx = '0; bus.clause_wr_data = '0;
        bus.num_clauses = '0; bus.assign_val = '0; bus.assign_def = '0; bus.start = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_conflict", 32'(bus.conflict), 0);
        chk("rst_unit_found", 32'(bus.unit_found), 0);
        chk("rst_unit_lit", 32'(bus.unit_lit), 0);
        ARESET = 1'b0;

        // empty slot 0 is a conflict
        scan(1, -10, 0, 40, dc, bn, bf, bl, da);
        chk("empty_done_cyc", dc, 2);
        chk("empty_done_pulse", 32'(da), 0);
        chk("empty_conflict", 32'(bus.conflict), 1);
        chk("empty_conflict_idx", 32'(bus.conflict_idx), 0);
        chk("empty_busy_n", bn, 1);

        // x1 | !x2 | x3
        wr(0, {7'h43, 7'h62, 7'h41});
        bus.assign_def = 32'h4; bus.assign_val = 32'h0;
        scan(1, -10, 0, 40, dc, bn, bf, bl, da);
        chk("sat_done_cyc", dc, 2);
        chk("sat_conflict", 32'(bus.conflict), 0);
        chk("sat_unit_found", 32'(bus.unit_found), 0);

        bus.assign_def = 32'h6; bus.assign_val = 32'h4;
        scan(1, -10, 0, 40, dc, bn, bf, bl, da);
        chk("unit_done_cyc", dc, 2);
        chk("unit_found", 32'(bus.unit_found), 1);
        chk("unit_lit", 32'(bus.unit_lit), 32'h43);
        chk("unit_idx", 32'(bus.unit_idx), 0);
        chk("unit_conflict", 32'(bus.conflict), 0);

        // early stop at slot 1 before the units in slots 2 and 3
        wr(0, {7'h00, 7'h45, 7'h45});
        wr(1, {7'h43, 7'h42, 7'h41});
        wr(2, {7'h00, 7'h00, 7'h44});
        wr(3, {7'h00, 7'h00, 7'h44});
        bus.assign_def = 32'hE; bus.assign_val = 32'h0;
        scan(4, -10, 0, 40, dc, bn, bf, bl, da);
        chk("cfl_done_cyc", dc, 3);
        chk("cfl_conflict", 32'(bus.conflict), 1);
        chk("cfl_conflict_idx", 32'(bus.conflict_idx), 1);
        chk("cfl_unit_found", 32'(bus.unit_found), 0);
        chk("cfl_busy_first", bf, 1);
        chk("cfl_busy_last", bl, 2);

        // 16 slots of two-unassigned clauses, units at slots 1 and 12
        for (int i = 0; i < 16; i++) begin
            if (i == 1)       wr(i, {7'h00, 7'h00, 7'h56});
            else if (i == 12) wr(i, {7'h00, 7'h00, 7'h57});
            else              wr(i, {7'h00, 7'h54, 7'h55});
        end
        bus.assign_def = 32'h0; bus.assign_val = 32'h0;
        scan(20, 5, 1, 40, dc, bn, bf, bl, da);
        chk("sat16_done_cyc", dc, 17);
        chk("sat16_busy_n", bn, 16);
        chk("sat16_done_pulse", 32'(da), 0);
        chk("sat16_conflict", 32'(bus.conflict), 0);
        chk("sat16_unit_found", 32'(bus.unit_found), 1);
        chk("sat16_unit_idx", 32'(bus.unit_idx), 1);
        chk("sat16_unit_lit", 32'(bus.unit_lit), 32'h56);
        repeat (3) @(posedge ACLK);
        #1;
        chk("hold_unit_idx", 32'(bus.unit_idx), 1);
        chk("hold_unit_lit", 32'(bus.unit_lit), 32'h56);
        chk("hold_done", 32'(bus.done), 0);

        // readback: the dropped write to slot 4 would show as a conflict
        scan(16, -10, 0, 40, dc, bn, bf, bl, da);
        chk("rb_done_cyc", dc, 17);
        chk("rb_conflict", 32'(bus.conflict), 0);
        chk("rb_unit_idx", 32'(bus.unit_idx), 1);

        scan(0, -10, 0, 40, dc, bn, bf, bl, da);
        chk("zero_done_cyc", dc, 1);
        chk("zero_busy_n", bn, 0);
        chk("zero_conflict", 32'(bus.conflict), 0);
        chk("zero_unit_found", 32'(bus.unit_found), 0);
        chk("zero_unit_lit", 32'(bus.unit_lit), 0);

        // reset during cycle T+3 of a 16-slot scan; unit at slot 1 already latched
        scan(16, 3, 2, 12, dc, bn, bf, bl, da);
        chk("mrst_no_done", dc, -1);
        chk("mrst_busy_n", bn, 3);
        chk("mrst_busy_last", bl, 3);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_unit_found", 32'(bus.unit_found), 0);
        chk("mrst_unit_lit", 32'(bus.unit_lit), 0);
        chk("mrst_unit_idx", 32'(bus.unit_idx), 0);
        chk("mrst_conflict", 32'(bus.conflict), 0);

        scan(1, -10, 0, 40, dc, bn, bf, bl, da);
        chk("post_rst_done_cyc", dc, 2);
        chk("post_rst_conflict", 32'(bus.conflict), 1);
        chk("post_rst_conflict_idx", 32'(bus.conflict_idx), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcp_clause_engine.md
Name: bcp_clause_engine

Overview:
- Compute core that sits directly downstream of the accelerator's AXI4-Lite slave register block.
- The register block decodes software writes into clause-load pulses, an assignment snapshot and a start pulse.
- This engine holds a small clause memory and scans it one clause per cycle against the current partial assignment.
- It reports the first unit clause (implied literal) or the first conflict back to the register block for software readback.

Parameters:
NUM_VARS, 32, number of boolean variables (assignment vector width)
VAR_W, 5, variable index width (clog2(NUM_VARS))
MAX_CLAUSES, 16, clause memory depth
CIDX_W, 4, clause index width (clog2(MAX_CLAUSES))
LITS, 3, literals per clause slot

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
clause_wr_en  in  1  write clause_wr_data into slot clause_wr_idx
clause_wr_idx  in  CIDX_W  clause slot index
clause_wr_data  in  LITS*(VAR_W+2)  literals, lit0 in LSBs; each literal is {valid, neg, var[VAR_W-1:0]}
num_clauses  in  CIDX_W+1  number of slots to scan, starting at slot 0
assign_val  in  NUM_VARS  variable values
assign_def  in  NUM_VARS  variable-assigned mask
start  in  1  one-cycle start pulse
busy  out  1  high while scanning
done  out  1  one-cycle completion pulse
conflict  out  1  a clause evaluated all-false
conflict_idx  out  CIDX_W  first conflicting clause
unit_found  out  1  at least one unit clause seen
unit_lit  out  VAR_W+2  implied literal of the first unit clause
unit_idx  out  CIDX_W  slot of the first unit clause

Behaviour:
- Reset values: every output 0.
- Reset state: FSM in IDLE; all clause slots cleared to zero, i.e. all literals invalid.
- States: IDLE, EVAL, FINISH.
- IDLE:
  - clause_wr_en writes the slot in the same cycle; the data is readable by the next scan.
  - start captures assign_val, assign_def and min(num_clauses, MAX_CLAUSES) into internal registers.
  - start also clears conflict, unit_found and all idx/lit outputs, sets ptr=0, and enters EVAL.
  - If the captured count is 0, start enters FINISH directly.
- EVAL: evaluate slot ptr once per cycle; busy=1. For each literal:
  - invalid -> ignored;
  - valid and !def[var] -> unassigned;
  - valid and def[var] and (val[var]^neg)==1 -> true;
  - otherwise -> false.
- Clause result:
  - any literal true -> satisfied, no action.
  - else 0 unassigned -> conflict. Set conflict=1 and conflict_idx=ptr, go to FINISH immediately (early stop).
  - else exactly 1 unassigned -> unit. If unit_found==0, set unit_found=1, unit_lit=that literal and unit_idx=ptr. Later units are ignored.
  - else (2 or more unassigned) -> no action.
  - A clause with no valid literals counts as a conflict.
- Transitions out of EVAL: ptr increments each cycle; after slot count-1, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start at cycle T, slot i evaluated in cycle T+1+i. done asserts at T+1+count with no conflict, or at T+2+k if slot k conflicts. With count=0, done asserts at T+1.
- Result hold: results remain stable from done until the next accepted start.
- start while busy (EVAL or FINISH): ignored, no effect on the scan.
- clause_wr_en while busy: dropped; memory unchanged.
- Simultaneous start and clause_wr_en in IDLE: the write completes, but the scan uses the new data only if the slot is reached after the write cycle. Software sequences writes before start.
- Assignment inputs changing during EVAL have no effect (snapshot).
- ARESET during EVAL: next cycle IDLE, all outputs 0, clause memory cleared, no done pulse.

Test Plan:
- Reset: ARESET high 3 cycles -> busy=done=conflict=unit_found=0. Then start with num_clauses=1 and no writes -> slot 0 is empty -> conflict=1, conflict_idx=0, done at T+2.
- Satisfied: slot0 = {0x43,0x62,0x41} (x1 | !x2 | x3), assign_def=0x4, assign_val=0, num_clauses=1, start at T -> done at T+2, conflict=0, unit_found=0.
- Unit: same clause, assign_def=0x6, assign_val=0x4 -> unit_found=1, unit_lit=0x43, unit_idx=0, conflict=0.
- Conflict early stop:
  - Clauses: slot0 = x5 unassigned twice (2 unassigned), slot1 = {x1,x2,x3} all defined false, slot2 and slot3 units.
  - Stimulus: assign_def=0xE, assign_val=0, num_clauses=4, start at T.
  - Required: done at T+3, conflict_idx=1, unit_found=0, busy high only in cycles T+1..T+2.
- Busy guards: num_clauses=20 -> 16 slots scanned, done at T+17. start and clause_wr_en pulsed at T+5 -> ignored, slot contents unchanged on readback scan. num_clauses=0 -> done at T+1, no flags.
- Reset mid-scan: ARESET at T+3 of a 16-clause scan -> busy=0 next cycle, no done pulse, all outputs 0. A following start with num_clauses=1 reports conflict (memory cleared).
